// File: rtl/decrypt_pipe_shift_core.sv
// Two-stage rotating-key shift decrypter: stage 1 classifies the byte and captures
// its key, stage 2 shifts alphabetic characters back by that key modulo 26.
module decrypt_pipe_shift_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] k1,
    input  logic [7:0] k2,
    input  logic [7:0] k3,
    input  logic [2:0] rot_freq,
    input  logic       shift_en,
    input  logic       mode,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_alpha,
    output logic       busy
);
    localparam int DATA_W = 8;

    function automatic logic [4:0] mod26(input logic [DATA_W-1:0] k);
        return 5'(k % 8'd26);
    endfunction

    // The offset minus the key lies in -25..25, so a single +26 wraps it back into range.
    function automatic logic [DATA_W-1:0] unshift(input logic [DATA_W-1:0] b,
                                                  input logic up,
                                                  input logic [4:0] key);
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] diff;
        logic signed [5:0] t;
        base = up ? 8'd65 : 8'd97;
        diff = b - base;
        t = $signed(diff[5:0]) - $signed({1'b0, key});
        if (t < 6'sd0)
            t = t + 6'sd26;
        return base + {2'b00, t};
    endfunction

    logic [4:0] km1, km2, km3;
    logic [2:0] rf_q;
    logic       act_q;
    logic [1:0] key_sel;
    logic [2:0] cnt;

    logic       stall, accept;
    logic       in_up, in_lo, in_alpha;
    logic [4:0] key_cur;

    logic              vld_p1;
    logic [DATA_W-1:0] b_p1;
    logic              up_p1;
    logic              alpha_p1;
    logic [4:0]        key_p1;

    assign stall     = dout_valid & ~dout_ready;
    assign din_ready = ~start & ~stall;
    assign accept    = din_valid & din_ready;
    assign busy      = vld_p1 | dout_valid;

    assign in_up    = (din >= 8'd65) && (din <= 8'd90);
    assign in_lo    = (din >= 8'd97) && (din <= 8'd122);
    assign in_alpha = act_q & (in_up | in_lo);

    always_comb begin
        case (key_sel)
            2'd1:    key_cur = km2;
            2'd2:    key_cur = km3;
            default: key_cur = km1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            km1     <= '0;
            km2     <= '0;
            km3     <= '0;
            rf_q    <= '0;
            act_q   <= 1'b0;
            key_sel <= '0;
            cnt     <= '0;
        end else if (start) begin
            km1     <= mod26(k1);
            km2     <= mod26(k2);
            km3     <= mod26(k3);
            rf_q    <= rot_freq;
            act_q   <= shift_en & mode;
            key_sel <= '0;
            cnt     <= '0;
        end else if (accept && in_alpha && rf_q != 3'd0) begin
            if (cnt == rf_q - 3'd1) begin
                cnt     <= '0;
                key_sel <= (key_sel == 2'd2) ? 2'd0 : key_sel + 2'd1;
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Stage 1: capture byte, class and key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld_p1 <= 1'b0;
        else if (!stall)
            vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            b_p1     <= din;
            up_p1    <= in_up;
            alpha_p1 <= in_alpha;
            key_p1   <= key_cur;
        end
    end

    // Stage 2: shift back and register outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_alpha <= 1'b0;
        end else if (!stall) begin
            dout_valid <= vld_p1;
            if (vld_p1) begin
                dout       <= alpha_p1 ? unshift(b_p1, up_p1, key_p1) : b_p1;
                dout_alpha <= alpha_p1;
            end
        end
    end
endmodule
